rename_queue: RTL and testbench

Decoupling FIFO between decode and the rename stage's mapping table. Decode pushes up to `RENAME_WIDTH` micro-ops per cycle. Rename pops up to `RENAME_WIDTH` oldest micro-ops per cycle, but only in cycles where the free list reports `allocatable`. The queue absorbs rename stalls and is emptied on branch-mispredict recovery.

---
 rtl/rename_queue.sv | 120 ++++++++++++
 tb/tb_rename_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_queue.sv
// Rename queue: multi-lane decoupling FIFO between decode and the rename mapping table.
// Valid push lanes are compacted in order; up to WIDTH oldest uops are presented and popped per cycle.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef ARF_INT_INDEX_SIZE
`define ARF_INT_INDEX_SIZE 5
`endif

module rename_queue #(
  parameter int WIDTH         = `RENAME_WIDTH,
  parameter int DEPTH         = 8,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int IDX_W         = `ARF_INT_INDEX_SIZE
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [WIDTH-1:0]                     in_valid,
  input  logic [WIDTH-1:0][IDX_W-1:0]          in_rs1,
  input  logic [WIDTH-1:0][IDX_W-1:0]          in_rs2,
  input  logic [WIDTH-1:0][IDX_W-1:0]          in_rd,
  input  logic [WIDTH-1:0]                     in_rd_valid,
  input  logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0]  in_payload,
  output logic                                 in_ready,
  output logic [WIDTH-1:0]                     out_valid,
  output logic [WIDTH-1:0][IDX_W-1:0]          out_rs1,
  output logic [WIDTH-1:0][IDX_W-1:0]          out_rs2,
  output logic [WIDTH-1:0][IDX_W-1:0]          out_rd,
  output logic [WIDTH-1:0]                     out_rd_valid,
  output logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0]  out_payload,
  input  logic                                 out_ready,
  output logic [$clog2(DEPTH+1)-1:0]           count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [IDX_W-1:0]         rs1;
    logic [IDX_W-1:0]         rs2;
    logic [IDX_W-1:0]         rd;
    logic                     rd_valid;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  entry_t                      mem_q [DEPTH];
  logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d, push_cnt, pop_cnt;
  logic [WIDTH-1:0][PTR_W-1:0] slot_off;
  logic                        push, pop;

  // in_ready depends on registered occupancy only, never on out_ready
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
  assign push     = in_ready && (|in_valid) && !flush;
  assign pop      = out_ready && !flush;
  assign pop_cnt  = !pop ? '0 : ((count_q < CNT_W'(WIDTH)) ? count_q : CNT_W'(WIDTH));

  // Slot offset of each lane = number of valid lanes below it (compaction)
  always_comb begin
    push_cnt = '0;
    slot_off = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot_off[i] = PTR_W'(push_cnt);
      push_cnt    = push_cnt + CNT_W'(in_valid[i]);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(pop_cnt);
      if (push) tail_d = tail_q + PTR_W'(push_cnt);
      count_d = count_q + (push ? push_cnt : '0) - pop_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; stale slots stay hidden behind out_valid
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_valid[i]) begin
          mem_q[tail_q + slot_off[i]] <= '{rs1: in_rs1[i], rs2: in_rs2[i], rd: in_rd[i],
                                          rd_valid: in_rd_valid[i], payload: in_payload[i]};
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    entry_t lane_e;
    assign out_valid[g]    = count_q > CNT_W'(g);
    assign lane_e          = out_valid[g] ? mem_q[head_q + PTR_W'(g)] : '0;
    assign out_rs1[g]      = lane_e.rs1;
    assign out_rs2[g]      = lane_e.rs2;
    assign out_rd[g]       = lane_e.rd;
    assign out_rd_valid[g] = lane_e.rd_valid;
    assign out_payload[g]  = lane_e.payload;
  end

  assign count = count_q;

endmodule

// File: tb/tb_rename_queue.sv
// Bench for rename_queue: directed scenarios plus random traffic against a queue-based model.
module tb_rename_queue;
  localparam int W  = 4;
  localparam int D  = 8;
  localparam int PW = 64;
  localparam int IW = 5;
  localparam int CW = $clog2(D+1);
  localparam int BW = W + 3*W*IW + W + W*PW + 1 + CW;

  logic                     clock = 1'b0;
  logic                     reset, flush, out_ready, in_ready;
  logic [W-1:0]             in_valid, in_rd_valid, out_valid, out_rd_valid;
  logic [W-1:0][IW-1:0]     in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [W-1:0][PW-1:0]     in_payload, out_payload;
  logic [CW-1:0]            count;
  logic [BW-1:0]            act;
  int                       checks = 0;
  int                       errors = 0;
  bit                       chk_en = 0;

  typedef struct {
    logic [IW-1:0] rs1, rs2, rd;
    logic          rdv;
    logic [PW-1:0] pl;
  } ent_t;
  ent_t mq[$];

  rename_queue #(.WIDTH(W), .DEPTH(D), .PAYLOAD_WIDTH(PW), .IDX_W(IW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_valid(in_rd_valid), .in_payload(in_payload), .in_ready(in_ready),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_valid(out_rd_valid), .out_payload(out_payload), .out_ready(out_ready),
    .count(count)
  );

  always #5 clock = ~clock;

  assign act = {out_valid, out_rs1, out_rs2, out_rd, out_rd_valid, out_payload, in_ready, count};

  // Expected observable outputs derived from the model queue contents
  function automatic logic [BW-1:0] exp_bundle();
    logic [W-1:0]         v   = '0;
    logic [W-1:0]         rdv = '0;
    logic [W-1:0][IW-1:0] r1  = '0;
    logic [W-1:0][IW-1:0] r2  = '0;
    logic [W-1:0][IW-1:0] rd  = '0;
    logic [W-1:0][PW-1:0] pl  = '0;
    logic                 rdy;
    for (int i = 0; i < W; i++) begin
      if (i < mq.size()) begin
        v[i] = 1'b1; r1[i] = mq[i].rs1; r2[i] = mq[i].rs2;
        rd[i] = mq[i].rd; rdv[i] = mq[i].rdv; pl[i] = mq[i].pl;
      end
    end
    rdy = (D - mq.size()) >= W;
    return {v, r1, r2, rd, rdv, pl, rdy, CW'(mq.size())};
  endfunction

  // One clock: model consumes the inputs seen at the edge, then we move to the negedge
  task automatic step();
    int n;
    bit rdy;
    @(posedge clock);
    rdy = (D - mq.size()) >= W;
    if (reset || flush) mq.delete();
    else begin
      if (out_ready) begin
        n = (mq.size() < W) ? mq.size() : W;
        repeat (n) void'(mq.pop_front());
      end
      if (rdy)
        for (int i = 0; i < W; i++)
          if (in_valid[i]) mq.push_back('{in_rs1[i], in_rs2[i], in_rd[i], in_rd_valid[i], in_payload[i]});
    end
    @(negedge clock);
  endtask

  task automatic idle();
    reset = 0; flush = 0; out_ready = 0; in_valid = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_valid = '0; in_payload = '0;
  endtask

  // Valid lanes get rd = base, base+1, ... in lane order; everything else is random
  task automatic drive_group(input logic [W-1:0] mask, input int base);
    int k = 0;
    in_valid = mask;
    for (int i = 0; i < W; i++) begin
      in_rs1[i]      = IW'($urandom);
      in_rs2[i]      = IW'($urandom);
      in_rd_valid[i] = 1'($urandom);
      in_payload[i]  = {$urandom, $urandom};
      if (mask[i]) begin in_rd[i] = IW'(base + k); k++; end
      else in_rd[i] = IW'($urandom);
    end
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      assert (count <= CW'(D) && 3'(dut.tail_q - dut.head_q) == count[2:0])
      else begin
        errors++;
        $display("FAIL invariant: count=%0d head=%0d tail=%0d", count, dut.head_q, dut.tail_q);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    chk_en = 1;
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_valid !== '0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_flags: out_valid=%b in_ready=%b want 0000/1", out_valid, in_ready); end
    checks++; if (out_rs1 !== '0 || out_rs2 !== '0 || out_rd !== '0 || out_rd_valid !== '0 || out_payload !== '0) begin
      errors++; $display("FAIL reset_data: rd=%h rdv=%b want 0", out_rd, out_rd_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    drive_group(4'b1111, 1); step(); idle();
    checks++; if (count !== 4 || out_valid !== 4'b1111 || in_ready !== 1'b1) begin errors++;
      $display("FAIL basic_push: count=%0d valid=%b rdy=%b want 4/1111/1", count, out_valid, in_ready); end
    checks++; if (out_rd !== {5'd4, 5'd3, 5'd2, 5'd1}) begin errors++;
      $display("FAIL basic_rd: got %h want {4,3,2,1}", out_rd); end
    checks++; if (act !== exp_bundle()) begin errors++;
      $display("FAIL basic_model: got %h want %h", act, exp_bundle()); end
    out_ready = 1; step(); idle();
    checks++; if (count !== 0 || out_valid !== 4'b0000) begin errors++;
      $display("FAIL basic_pop: count=%0d valid=%b want 0/0000", count, out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    drive_group(4'b1111, 1); step();
    drive_group(4'b1111, 5); step(); idle();
    checks++; if (count !== 8 || in_ready !== 1'b0 || out_valid !== 4'b1111) begin errors++;
      $display("FAIL full: count=%0d rdy=%b valid=%b want 8/0/1111", count, in_ready, out_valid); end
    drive_group(4'b1111, 9); step(); idle();
    checks++; if (count !== 8 || out_rd !== {5'd4, 5'd3, 5'd2, 5'd1}) begin errors++;
      $display("FAIL full_ignore: count=%0d rd=%h want 8/{4,3,2,1}", count, out_rd); end
    out_ready = 1; step();
    checks++; if (out_rd !== {5'd8, 5'd7, 5'd6, 5'd5} || act !== exp_bundle()) begin errors++;
      $display("FAIL full_drain: got %h want %h", act, exp_bundle()); end
    step(); idle();
    checks++; if (count !== 0) begin errors++; $display("FAIL full_empty: count=%0d want 0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_group(4'b1111, 1); step(); idle(); out_ready = 1; step(); idle();
    drive_group(4'b0011, 5); step(); idle(); out_ready = 1; step(); idle();
    drive_group(4'b1010, 7); step(); idle();
    checks++; if (out_valid !== 4'b0011 || out_rd[0] !== 5'd7 || out_rd[1] !== 5'd8) begin errors++;
      $display("FAIL compact: valid=%b rd=%h want 0011 lane0=7 lane1=8", out_valid, out_rd); end
    drive_group(4'b1111, 9); step(); idle();
    checks++; if (count !== 6 || out_rd !== {5'd10, 5'd9, 5'd8, 5'd7}) begin errors++;
      $display("FAIL wrap_push: count=%0d rd=%h want 6/{10,9,8,7}", count, out_rd); end
    out_ready = 1; step(); idle();
    checks++; if (count !== 2 || {out_rd[1], out_rd[0]} !== {5'd12, 5'd11} || act !== exp_bundle()) begin errors++;
      $display("FAIL wrap_pop: got %h want %h", act, exp_bundle()); end
  endtask

  task automatic test_simul();
    do_reset();
    drive_group(4'b1111, 1); step();
    drive_group(4'b0011, 5); step(); idle();
    drive_group(4'b1111, 20); out_ready = 1;
    checks++; if (in_ready !== 1'b0 || count !== 6) begin errors++;
      $display("FAIL simul_rdy6: rdy=%b count=%0d want 0/6", in_ready, count); end
    step(); idle();
    checks++; if (count !== 2 || out_valid !== 4'b0011 || {out_rd[1], out_rd[0]} !== {5'd6, 5'd5}) begin errors++;
      $display("FAIL simul_drop: count=%0d rd=%h want 2/{6,5}", count, out_rd); end
    drive_group(4'b0011, 7); step(); idle();
    drive_group(4'b1111, 24); out_ready = 1;
    checks++; if (in_ready !== 1'b1 || out_rd !== {5'd8, 5'd7, 5'd6, 5'd5}) begin errors++;
      $display("FAIL simul_pre4: rdy=%b rd=%h want 1/{8,7,6,5}", in_ready, out_rd); end
    step(); idle();
    checks++; if (count !== 4 || out_rd !== {5'd27, 5'd26, 5'd25, 5'd24} || act !== exp_bundle()) begin errors++;
      $display("FAIL simul_both: got %h want %h", act, exp_bundle()); end
  endtask

  task automatic test_partial();
    do_reset();
    drive_group(4'b0111, 1); step(); idle();
    out_ready = 1;
    checks++; if (out_valid !== 4'b0111 || out_rd[3] !== '0 || out_rd_valid[3] !== 1'b0 ||
                  out_rs1[3] !== '0 || out_rs2[3] !== '0 || out_payload[3] !== '0) begin errors++;
      $display("FAIL partial_lane3: valid=%b rd3=%0d rdv3=%b want 0111/0/0", out_valid, out_rd[3], out_rd_valid[3]); end
    step(); idle();
    checks++; if (count !== 0 || out_valid !== 4'b0000) begin errors++;
      $display("FAIL partial_pop: count=%0d valid=%b want 0/0000", count, out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_group(4'b1111, 1); step();
    drive_group(4'b0001, 5); step();
    drive_group(4'b1111, 10); out_ready = 1; flush = 1; step(); idle();
    checks++; if (count !== 0 || out_valid !== 4'b0000 || in_ready !== 1'b1) begin errors++;
      $display("FAIL flush: count=%0d valid=%b rdy=%b want 0/0000/1", count, out_valid, in_ready); end
    step(); step();
    checks++; if (count !== 0 || out_valid !== 4'b0000) begin errors++;
      $display("FAIL flush_stale: count=%0d valid=%b want 0/0000", count, out_valid); end
    drive_group(4'b0111, 1); step(); idle();
    reset = 1; flush = 1; drive_group(4'b1111, 9); out_ready = 1; step(); idle();
    checks++; if (count !== 0 || out_valid !== 4'b0000 || in_ready !== 1'b1 || out_rd !== '0) begin errors++;
      $display("FAIL reset_flush: count=%0d valid=%b rdy=%b want 0/0000/1", count, out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive_group(4'b1111, (c * 4) % 32); out_ready = 1; step();
      checks++; if (count !== 4 || act !== exp_bundle()) begin errors++;
        $display("FAIL b2b[%0d]: got %h want %h", c, act, exp_bundle()); end
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_group(4'($urandom), $urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step();
      checks++; if (act !== exp_bundle()) begin errors++;
        $display("FAIL random[%0d]: got %h want %h", c, act, exp_bundle()); end
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clock);
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simul();
    test_partial();
    test_flush();
    test_back_to_back();
    test_random();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
